ysyx_22050710_sram_arbiter: RTL and testbench

YSYX_22050710_SRAM_ARBITER -- requirements
Module: ysyx_22050710_sram_arbiter

---
 rtl/ysyx_22050710_sram_arbiter.sv | 191 +++++++++++++++++++
 tb/tb_ysyx_22050710_sram_arbiter.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_22050710_sram_arbiter.sv
// N-to-1 arbiter for SRAM-like request/response channels.
// Grants one master channel onto a single downstream port (fixed priority or
// round-robin), holds the grant stable while the downstream stalls, and
// routes in-order responses back using an ID FIFO of outstanding requests.
module ysyx_22050710_sram_arbiter #(
    parameter int N_CH          = 2,
    parameter int SRAM_ADDR_WD  = 32,
    parameter int SRAM_DATA_WD  = 64,
    parameter int SRAM_WMASK_WD = 8,
    parameter int OST_DEPTH     = 4,
    parameter int ARB_MODE      = 1
) (
    input  logic                              i_clk,
    input  logic                              i_rst_n,
    input  logic [N_CH-1:0]                   i_m_req,
    input  logic [N_CH-1:0]                   i_m_op,
    input  logic [N_CH*2-1:0]                 i_m_size,
    input  logic [N_CH*SRAM_ADDR_WD-1:0]      i_m_addr,
    input  logic [N_CH*SRAM_WMASK_WD-1:0]     i_m_wstrb,
    input  logic [N_CH*SRAM_DATA_WD-1:0]      i_m_wdata,
    output logic [N_CH-1:0]                   o_m_addr_ok,
    output logic [N_CH-1:0]                   o_m_data_ok,
    output logic [SRAM_DATA_WD-1:0]           o_m_rdata,
    output logic                              o_s_req,
    output logic                              o_s_op,
    output logic [1:0]                        o_s_size,
    output logic [SRAM_ADDR_WD-1:0]           o_s_addr,
    output logic [SRAM_WMASK_WD-1:0]          o_s_wstrb,
    output logic [SRAM_DATA_WD-1:0]           o_s_wdata,
    input  logic                              i_s_addr_ok,
    input  logic                              i_s_data_ok,
    input  logic [SRAM_DATA_WD-1:0]           i_s_rdata,
    output logic [$clog2(OST_DEPTH):0]        o_ost_cnt,
    output logic                              o_err
);

    localparam int IDX_W = (N_CH > 1) ? $clog2(N_CH) : 1;
    localparam int PTR_W = $clog2(OST_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    // Per-channel views of the packed request buses
    logic [SRAM_ADDR_WD-1:0]  w_addr_arr  [N_CH];
    logic [SRAM_WMASK_WD-1:0] w_wstrb_arr [N_CH];
    logic [SRAM_DATA_WD-1:0]  w_wdata_arr [N_CH];
    logic [1:0]               w_size_arr  [N_CH];

    // Arbitration state
    logic [IDX_W-1:0] r_rr_ptr;
    logic             r_lock_vld;
    logic [IDX_W-1:0] r_lock_idx;

    // Outstanding-ID FIFO state
    logic [IDX_W-1:0] r_fifo [OST_DEPTH];
    logic [PTR_W-1:0] r_wptr;
    logic [PTR_W-1:0] r_rptr;
    logic [CNT_W-1:0] r_cnt;
    logic             r_err;

    logic [IDX_W-1:0] w_fp_idx;
    logic [IDX_W-1:0] w_rr_idx;
    logic [IDX_W-1:0] w_arb_idx;
    logic [IDX_W-1:0] w_grant;
    logic [IDX_W-1:0] w_rr_next;
    logic [IDX_W-1:0] w_head;
    logic             w_full;
    logic             w_hs;
    logic             w_pop;
    logic             w_spur;

    genvar gi;
    generate
        for (gi = 0; gi < N_CH; gi++) begin : g_unpack
            assign w_addr_arr[gi]  = i_m_addr[gi*SRAM_ADDR_WD +: SRAM_ADDR_WD];
            assign w_wstrb_arr[gi] = i_m_wstrb[gi*SRAM_WMASK_WD +: SRAM_WMASK_WD];
            assign w_wdata_arr[gi] = i_m_wdata[gi*SRAM_DATA_WD +: SRAM_DATA_WD];
            assign w_size_arr[gi]  = i_m_size[gi*2 +: 2];
        end
    endgenerate

    // Fixed priority: lowest requesting index wins
    always_comb begin
        w_fp_idx = '0;
        for (int i = N_CH - 1; i >= 0; i--) begin
            if (i_m_req[i]) begin
                w_fp_idx = IDX_W'(i);
            end
        end
    end

    // Round-robin: first requester at or after r_rr_ptr, wrapping modulo N_CH
    always_comb begin
        logic [IDX_W:0] v_cand;
        logic           v_found;
        w_rr_idx = r_rr_ptr;
        v_cand   = '0;
        v_found  = 1'b0;
        for (int i = 0; i < N_CH; i++) begin
            v_cand = {1'b0, r_rr_ptr} + (IDX_W+1)'(i);
            if (v_cand >= (IDX_W+1)'(N_CH)) begin
                v_cand = v_cand - (IDX_W+1)'(N_CH);
            end
            if (!v_found && i_m_req[v_cand[IDX_W-1:0]]) begin
                w_rr_idx = v_cand[IDX_W-1:0];
                v_found  = 1'b1;
            end
        end
    end

    // A stalled request keeps its channel until the downstream accepts it
    assign w_arb_idx = (ARB_MODE == 0) ? w_fp_idx : w_rr_idx;
    assign w_grant   = r_lock_vld ? r_lock_idx : w_arb_idx;
    assign w_rr_next = (w_grant == IDX_W'(N_CH - 1)) ? '0 : w_grant + 1'b1;

    assign w_full  = (r_cnt == CNT_W'(OST_DEPTH));
    assign o_s_req = i_rst_n & (|i_m_req) & ~w_full;
    assign w_hs    = o_s_req & i_s_addr_ok;

    assign o_s_op    = i_m_op[w_grant];
    assign o_s_size  = w_size_arr[w_grant];
    assign o_s_addr  = w_addr_arr[w_grant];
    assign o_s_wstrb = w_wstrb_arr[w_grant];
    assign o_s_wdata = w_wdata_arr[w_grant];

    // Responses return in order, so the FIFO head names their owner.
    // The head is read combinationally because data_ok is routed in the
    // same cycle it arrives.
    assign w_head = r_fifo[r_rptr];
    assign w_pop  = i_rst_n & i_s_data_ok & (r_cnt != '0);
    assign w_spur = i_s_data_ok & (r_cnt == '0);

    generate
        for (gi = 0; gi < N_CH; gi++) begin : g_route
            assign o_m_addr_ok[gi] = w_hs  & (w_grant == IDX_W'(gi));
            assign o_m_data_ok[gi] = w_pop & (w_head  == IDX_W'(gi));
        end
    endgenerate

    assign o_m_rdata = i_s_rdata;
    assign o_ost_cnt = r_cnt;
    assign o_err     = r_err;

    // Round-robin pointer and stall lock
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_rr_ptr   <= '0;
            r_lock_vld <= 1'b0;
            r_lock_idx <= '0;
        end else if (w_hs) begin
            r_lock_vld <= 1'b0;
            if (ARB_MODE == 1) begin
                r_rr_ptr <= w_rr_next;
            end
        end else if (o_s_req) begin
            r_lock_vld <= 1'b1;
            r_lock_idx <= w_grant;
        end
    end

    // ID storage; contents are meaningless outside the valid window
    always_ff @(posedge i_clk) begin
        if (w_hs) begin
            r_fifo[r_wptr] <= w_grant;
        end
    end

    // FIFO pointers, occupancy and sticky error for data_ok with nothing outstanding
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wptr <= '0;
            r_rptr <= '0;
            r_cnt  <= '0;
            r_err  <= 1'b0;
        end else begin
            if (w_hs) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + 1'b1;
            end
            case ({w_hs, w_pop})
                2'b10:   r_cnt <= r_cnt + 1'b1;
                2'b01:   r_cnt <= r_cnt - 1'b1;
                default: r_cnt <= r_cnt;
            endcase
            if (w_spur) begin
                r_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_ysyx_22050710_sram_arbiter.sv
// Directed bench: one round-robin and one fixed-priority instance share the
// same stimulus. Expected grants/responses are queued as each cycle is driven
// and a negedge monitor pops and compares whenever a handshake appears.
module tb_ysyx_22050710_sram_arbiter;

    localparam logic [31:0] A0 = 32'h0000_0100;
    localparam logic [31:0] A1 = 32'h2000_0200;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  m_req;
    logic [1:0]  m_op   = 2'b10;
    logic [3:0]  m_size = 4'b1011;
    logic [63:0] m_addr = {A1, A0};
    logic [15:0] m_wstrb = 16'hF00F;
    logic [127:0] m_wdata = {64'h1111_2222_3333_4444, 64'h5555_6666_7777_8888};
    logic        s_addr_ok;
    logic        s_data_ok;
    logic [63:0] s_rdata;

    logic [1:0]  rr_addr_ok, rr_data_ok, fp_addr_ok, fp_data_ok;
    logic [63:0] rr_rdata, fp_rdata, rr_wdata, fp_wdata;
    logic        rr_s_req, rr_s_op, fp_s_req, fp_s_op;
    logic [1:0]  rr_s_size, fp_s_size;
    logic [31:0] rr_s_addr, fp_s_addr;
    logic [7:0]  rr_wstrb, fp_wstrb;
    logic [2:0]  rr_cnt, fp_cnt;
    logic        rr_err, fp_err;

    int checks = 0;
    int errors = 0;

    typedef struct packed { logic [1:0] oh; logic [31:0] addr; logic op; } a_exp_t;
    typedef struct packed { logic [1:0] oh; logic [63:0] rdata; } d_exp_t;
    a_exp_t q_rr_a[$];
    a_exp_t q_fp_a[$];
    d_exp_t q_rr_d[$];

    always #5 clk = ~clk;

    ysyx_22050710_sram_arbiter #(.N_CH(2), .OST_DEPTH(4), .ARB_MODE(1)) u_rr (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_m_req(m_req), .i_m_op(m_op), .i_m_size(m_size), .i_m_addr(m_addr),
        .i_m_wstrb(m_wstrb), .i_m_wdata(m_wdata),
        .o_m_addr_ok(rr_addr_ok), .o_m_data_ok(rr_data_ok), .o_m_rdata(rr_rdata),
        .o_s_req(rr_s_req), .o_s_op(rr_s_op), .o_s_size(rr_s_size), .o_s_addr(rr_s_addr),
        .o_s_wstrb(rr_wstrb), .o_s_wdata(rr_wdata),
        .i_s_addr_ok(s_addr_ok), .i_s_data_ok(s_data_ok), .i_s_rdata(s_rdata),
        .o_ost_cnt(rr_cnt), .o_err(rr_err)
    );

    ysyx_22050710_sram_arbiter #(.N_CH(2), .OST_DEPTH(4), .ARB_MODE(0)) u_fp (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_m_req(m_req), .i_m_op(m_op), .i_m_size(m_size), .i_m_addr(m_addr),
        .i_m_wstrb(m_wstrb), .i_m_wdata(m_wdata),
        .o_m_addr_ok(fp_addr_ok), .o_m_data_ok(fp_data_ok), .o_m_rdata(fp_rdata),
        .o_s_req(fp_s_req), .o_s_op(fp_s_op), .o_s_size(fp_s_size), .o_s_addr(fp_s_addr),
        .o_s_wstrb(fp_wstrb), .o_s_wdata(fp_wdata),
        .i_s_addr_ok(s_addr_ok), .i_s_data_ok(s_data_ok), .i_s_rdata(s_rdata),
        .o_ost_cnt(fp_cnt), .o_err(fp_err)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s t=%0t act=%h exp=%h", nm, $time, act, exp);
        end
    endtask

    function automatic a_exp_t mk_a(input int ch);
        a_exp_t e;
        e.oh   = (ch == 1) ? 2'b10 : 2'b01;
        e.addr = (ch == 1) ? A1 : A0;
        e.op   = (ch == 1) ? 1'b1 : 1'b0;
        return e;
    endfunction

    // One bus cycle: drive after the edge, queue expectations, return at negedge
    task automatic cyc(input logic [1:0] req, input logic aok, input logic dok,
                       input logic [63:0] rd, input int rr_g, input int fp_g, input int rr_d);
        d_exp_t d;
        @(posedge clk);
        #1;
        m_req = req; s_addr_ok = aok; s_data_ok = dok; s_rdata = rd;
        if (rr_g >= 0) q_rr_a.push_back(mk_a(rr_g));
        if (fp_g >= 0) q_fp_a.push_back(mk_a(fp_g));
        if (rr_d >= 0) begin
            d.oh = (rr_d == 1) ? 2'b10 : 2'b01;
            d.rdata = rd;
            q_rr_d.push_back(d);
        end
        $display("cyc t=%0t req=%b aok=%b dok=%b exp_rr=%0d exp_fp=%0d exp_rrd=%0d",
                 $time, req, aok, dok, rr_g, fp_g, rr_d);
        @(negedge clk);
    endtask

    // Monitor: compare each presented handshake with the oldest expectation
    always @(negedge clk) begin
        a_exp_t ea;
        d_exp_t ed;
        if (rst_n === 1'b1) begin
            if (rr_addr_ok != 2'b00) begin
                if (q_rr_a.size() == 0) chk("rr_addr_ok_unexpected", 64'(rr_addr_ok), 64'd0);
                else begin
                    ea = q_rr_a.pop_front();
                    chk("rr_addr_ok", 64'(rr_addr_ok), 64'(ea.oh));
                    chk("rr_s_addr", 64'(rr_s_addr), 64'(ea.addr));
                    chk("rr_s_op", 64'(rr_s_op), 64'(ea.op));
                end
            end
            if (fp_addr_ok != 2'b00) begin
                if (q_fp_a.size() == 0) chk("fp_addr_ok_unexpected", 64'(fp_addr_ok), 64'd0);
                else begin
                    ea = q_fp_a.pop_front();
                    chk("fp_addr_ok", 64'(fp_addr_ok), 64'(ea.oh));
                    chk("fp_s_addr", 64'(fp_s_addr), 64'(ea.addr));
                end
            end
            if (rr_data_ok != 2'b00) begin
                if (q_rr_d.size() == 0) chk("rr_data_ok_unexpected", 64'(rr_data_ok), 64'd0);
                else begin
                    ed = q_rr_d.pop_front();
                    chk("rr_data_ok", 64'(rr_data_ok), 64'(ed.oh));
                    chk("rr_rdata", rr_rdata, ed.rdata);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog t=%0t act=running exp=finished", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; m_req = 2'b11; s_addr_ok = 1'b1; s_data_ok = 1'b1; s_rdata = '0;
        @(negedge clk); @(negedge clk);
        chk("rst_s_req", 64'(rr_s_req), 64'd0);
        chk("rst_fp_s_req", 64'(fp_s_req), 64'd0);
        chk("rst_addr_ok", 64'(rr_addr_ok), 64'd0);
        chk("rst_data_ok", 64'(rr_data_ok), 64'd0);
        chk("rst_cnt", 64'(rr_cnt), 64'd0);
        chk("rst_err", 64'(rr_err), 64'd0);
        m_req = 2'b00; s_addr_ok = 1'b0; s_data_ok = 1'b0;
        rst_n = 1'b1;

        // Alternating round-robin grants, fixed priority sticks to ch0, fill to 4
        cyc(2'b11, 1, 0, 64'd0, 0, 0, -1);
        cyc(2'b11, 1, 0, 64'd0, 1, 0, -1);
        cyc(2'b11, 1, 0, 64'd0, 0, 0, -1);
        cyc(2'b11, 1, 0, 64'd0, 1, 0, -1);
        cyc(2'b11, 1, 0, 64'd0, -1, -1, -1);
        chk("full_cnt", 64'(rr_cnt), 64'd4);
        chk("full_s_req", 64'(rr_s_req), 64'd0);
        chk("full_fp_cnt", 64'(fp_cnt), 64'd4);
        cyc(2'b11, 1, 1, 64'hD000_0000_0000_0001, -1, -1, 0);
        chk("full_pop_s_req", 64'(rr_s_req), 64'd0);
        cyc(2'b11, 1, 0, 64'd0, 0, 0, -1);
        chk("reenter_cnt", 64'(rr_cnt), 64'd3);
        chk("reenter_s_req", 64'(rr_s_req), 64'd1);
        cyc(2'b00, 0, 1, 64'hD000_0000_0000_0002, -1, -1, 1);
        cyc(2'b00, 0, 1, 64'hD000_0000_0000_0003, -1, -1, 0);
        cyc(2'b00, 0, 1, 64'hD000_0000_0000_0004, -1, -1, 1);
        cyc(2'b00, 0, 1, 64'hD000_0000_0000_0005, -1, -1, 0);
        cyc(2'b00, 0, 0, 64'd0, -1, -1, -1);
        chk("drain_cnt", 64'(rr_cnt), 64'd0);
        chk("drain_err", 64'(rr_err), 64'd0);

        // Fixed priority grants ch1 only when ch0 is idle
        cyc(2'b10, 1, 0, 64'd0, 1, 1, -1);
        cyc(2'b00, 0, 1, 64'hD000_0000_0000_0006, -1, -1, 1);

        // Stall on ch1 while ch0 joins: grant and address must hold
        cyc(2'b10, 0, 0, 64'd0, -1, -1, -1);
        chk("lock_addr0", 64'(rr_s_addr), 64'(A1));
        cyc(2'b11, 0, 0, 64'd0, -1, -1, -1);
        chk("lock_addr1", 64'(rr_s_addr), 64'(A1));
        chk("lock_fp_addr1", 64'(fp_s_addr), 64'(A1));
        cyc(2'b11, 0, 0, 64'd0, -1, -1, -1);
        chk("lock_addr2", 64'(rr_s_addr), 64'(A1));
        chk("lock_fp_addr2", 64'(fp_s_addr), 64'(A1));
        cyc(2'b11, 1, 0, 64'd0, 1, 1, -1);
        cyc(2'b11, 1, 0, 64'd0, 0, 0, -1);

        // Push and pop together at count 2
        cyc(2'b10, 1, 1, 64'hD000_0000_0000_0007, 1, 1, 1);
        cyc(2'b00, 0, 0, 64'd0, -1, -1, -1);
        chk("pushpop_cnt", 64'(rr_cnt), 64'd2);
        cyc(2'b00, 0, 1, 64'hD000_0000_0000_0008, -1, -1, 0);
        cyc(2'b00, 0, 1, 64'hD000_0000_0000_0009, -1, -1, 1);

        // Spurious data_ok, then reset with three requests in flight
        cyc(2'b00, 0, 1, 64'hD000_0000_0000_000A, -1, -1, -1);
        cyc(2'b00, 0, 0, 64'd0, -1, -1, -1);
        chk("spur_err", 64'(rr_err), 64'd1);
        chk("spur_cnt", 64'(rr_cnt), 64'd0);
        cyc(2'b11, 1, 0, 64'd0, 0, 0, -1);
        cyc(2'b11, 1, 0, 64'd0, 1, 0, -1);
        cyc(2'b11, 1, 0, 64'd0, 0, 0, -1);
        cyc(2'b11, 0, 0, 64'd0, -1, -1, -1);
        chk("pre_rst_cnt", 64'(rr_cnt), 64'd3);
        m_req = 2'b00; s_addr_ok = 1'b0; s_data_ok = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_cnt", 64'(rr_cnt), 64'd0);
        chk("mid_rst_err", 64'(rr_err), 64'd0);
        chk("mid_rst_s_req", 64'(rr_s_req), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        cyc(2'b11, 1, 0, 64'd0, 0, 0, -1);
        chk("post_rst_err", 64'(rr_err), 64'd0);
        cyc(2'b00, 0, 1, 64'hD000_0000_0000_000B, -1, -1, 0);
        cyc(2'b00, 0, 1, 64'hD000_0000_0000_000C, -1, -1, -1);
        cyc(2'b00, 0, 0, 64'd0, -1, -1, -1);
        chk("post_rst_spur_err", 64'(rr_err), 64'd1);
        chk("post_rst_cnt", 64'(rr_cnt), 64'd0);

        chk("rr_a_left", 64'(q_rr_a.size()), 64'd0);
        chk("fp_a_left", 64'(q_fp_a.size()), 64'd0);
        chk("rr_d_left", 64'(q_rr_d.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
